// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - registered N-way selector with valid/ready flow control and error tracking
// Define MUX_PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module mux_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 err_sticky,
    output logic [15:0]          err_count,
    input  logic                 err_clr
);

    localparam logic [SELW:0] NL = (SELW+1)'(N);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_acc;
    logic             w_acc_err;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;
    logic             r_err_sticky;
    logic [15:0]      r_err_count;

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_err = ({1'b0, sel} >= NL);
    assign w_acc     = in_valid && in_ready;
    assign w_acc_err = w_acc && w_sel_err;

    // Clear takes effect before the same-cycle error is recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 16'h0000;
        end else if (err_clr) begin
            r_err_sticky <= w_acc_err;
            r_err_count  <= w_acc_err ? 16'h0001 : 16'h0000;
        end else if (w_acc_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'h0001;
            end
        end
    end

`ifdef MUX_PIPE_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sel_data;
                        r_out_err   <= w_sel_err;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_acc && !out_ready) begin
                        r_skid_data <= w_sel_data;
                        r_skid_err  <= w_sel_err;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_FULL;
                    end else if (w_acc) begin
                        r_out_data <= w_sel_data;
                        r_out_err  <= w_sel_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_out_data <= r_skid_data;
                        r_out_err  <= r_skid_err;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_err   <= w_sel_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready = !r_out_valid || out_ready;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - scoreboard bench for mux_pipe (N=3, WIDTH=32)
module tb_mux_pipe;

    localparam int WIDTH = 32;
    localparam int N     = 3;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sel;
    logic [N*WIDTH-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_err;
    logic              err_sticky;
    logic [15:0]       err_count;
    logic              err_clr;

    int tests;
    int fails;

    logic [WIDTH:0] q[$];
    logic           prev_stall;
    logic [WIDTH:0] prev_beat;

    mux_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_sticky(err_sticky), .err_count(err_count), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model(input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, 32'h11111111};
            2'd1:    return {1'b0, 32'h22222222};
            2'd2:    return {1'b0, 32'h33333333};
            default: return {1'b1, 32'h00000000};
        endcase
    endfunction

    // Scoreboard: push on accept, pop on drain, and watch for stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || {out_err, out_data} !== prev_beat) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h", out_valid, {out_err, out_data}, prev_beat);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h required none", {out_err, out_data});
                end else begin
                    logic [WIDTH:0] exp_b;
                    exp_b = q.pop_front();
                    if ({out_err, out_data} !== exp_b) begin
                        fails++;
                        $display("FAIL beat_order: got %h required %h", {out_err, out_data}, exp_b);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(sel));
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_err, out_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; sel = 2'd0; out_ready = 1'b0; err_clr = 1'b0;
        data_in = {32'h33333333, 32'h22222222, 32'h11111111};
        repeat (3) step();
        tests++;
        if ({out_valid, out_data, out_err, err_sticky, err_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b s=%b c=%h required all 0", out_valid, out_data, out_err, err_sticky, err_count);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        reset_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h22222222 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL single_beat: got v=%b d=%h e=%b required v=1 d=22222222 e=0", out_valid, out_data, out_err);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_error();
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_data !== 32'h0 || out_err !== 1'b1 || err_sticky !== 1'b1 || err_count !== 16'd1) begin
            fails++;
            $display("FAIL error_beat: got d=%h e=%b s=%b c=%h required d=0 e=1 s=1 c=0001", out_data, out_err, err_sticky, err_count);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests++;
        if (err_count !== 16'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL error_clear: got s=%b c=%h required s=0 c=0000", err_sticky, err_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sels[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [WIDTH:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sel = sels[i];
            step();
            e = model(sels[i]);
            tests++;
            if (out_valid !== 1'b1 || out_data !== e[WIDTH-1:0]) begin
                fails++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h required v=1 d=%h", i, out_valid, out_data, e[WIDTH-1:0]);
            end
        end
        in_valid = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_stall();
        logic [1:0] sels[3] = '{2'd2, 2'd0, 2'd1};
        int idx = 0;
        int exp_acc;
        int budget = 0;
`ifdef MUX_PIPE_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3); sel = sels[idx < 3 ? idx : 0];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            step();
        end
        tests++;
        if (idx != exp_acc || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_accepts: got acc=%0d rdy=%b required acc=%0d rdy=0", idx, in_ready, exp_acc);
        end
        out_ready = 1'b1;
        while (idx < 3 && budget < 20) begin
            in_valid = 1'b1; sel = sels[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            step();
            budget++;
        end
        in_valid = 1'b0;
        repeat (4) step();
        tests++;
        if (idx != 3 || q.size() != 0) begin
            fails++;
            $display("FAIL stall_release: got acc=%0d pending=%0d required acc=3 pending=0", idx, q.size());
        end
    endtask

    task automatic test_saturate();
        force dut.r_err_count = 16'hFFFE;
        #1;
        release dut.r_err_count;
        tests++;
        if (err_count !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_preload: got %h required fffe", err_count);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = 2'd3;
            step();
            tests++;
            if (err_count !== 16'hFFFF) begin
                fails++;
                $display("FAIL sat_count%0d: got %h required ffff", i, err_count);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_clr_with_err();
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3; err_clr = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b0;
        tests++;
        if (err_count !== 16'd1 || err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL clr_with_err: got s=%b c=%h required s=1 c=0001", err_sticky, err_count);
        end
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = 2'(i);
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL prefill: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_err, err_sticky, err_count} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset: got v=%b d=%h e=%b s=%b c=%h rdy=%b required zeros rdy=1", out_valid, out_data, out_err, err_sticky, err_count, in_ready);
        end
        q.delete();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_beat%0d: got v=%b required 0", i, out_valid);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_stall = 1'b0;
        prev_beat = '0;
        test_reset();
        test_single();
        test_error();
        test_back_to_back();
        test_stall();
        test_saturate();
        test_clr_with_err();
        test_reset_full();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL final_queue: got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
